// File: rtl/im_fetch_ctrl.sv
// Input-memory fetch sequencer: per job, streams NTILE tiles of four IM column words
// into the IM pipeline buffer and handshakes each tile with the MAC array.
module im_fetch_ctrl #(
    parameter int ADDR_W = 6
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              START,
    input  logic [3:0]        NTILE,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [4:0]        CFG_SHAMT,
    input  logic [3:0]        ODST_BASE,
    input  logic              CALC_DONE,
    output logic              IM_REN,
    output logic [ADDR_W-1:0] IM_ADDR,
    input  logic [31:0]       IM_RDATA,
    output logic [31:0]       IDATA1,
    output logic              ILoad1,
    output logic [1:0]        ICOL1,
    output logic [4:0]        shamt1,
    output logic [3:0]        ODST1,
    output logic              START_CALC1,
    output logic              BUSY,
    output logic              DONE
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [1:0]        col_r;
    logic [3:0]        tile_r;
    logic [3:0]        ntile_r;
    logic [ADDR_W-1:0] base_r;
    logic              iload_r;
    logic [1:0]        icol_r;
    logic [4:0]        shamt_r;
    logic [3:0]        odst_r;
    logic              start_calc_r;
    logic              done_r;
    logic              accept_s;
    logic              empty_s;
    logic              next_tile_s;
    logic              job_end_s;
    logic              more_s;
    logic              im_ren_s;
    logic [ADDR_W-1:0] im_addr_s;

    // Widened compare so tile+1 cannot wrap when NTILE is 15.
    assign more_s = ({1'b0, tile_r} + 5'd1) < {1'b0, ntile_r};

    // Next-state and job-event decode.
    always_comb begin
        state_s     = state_r;
        accept_s    = 1'b0;
        empty_s     = 1'b0;
        next_tile_s = 1'b0;
        job_end_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (START) begin
                    if (NTILE != 4'd0) begin
                        state_s  = ST_FETCH;
                        accept_s = 1'b1;
                    end else begin
                        empty_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (col_r == 2'd3) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DRAIN: state_s = ST_WAIT;
            ST_WAIT: begin
                if (CALC_DONE) begin
                    if (more_s) begin
                        state_s     = ST_FETCH;
                        next_tile_s = 1'b1;
                    end else begin
                        state_s   = ST_IDLE;
                        job_end_s = 1'b1;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // IM read request; {tile, col} is exactly 4*tile + col.
    always_comb begin
        im_ren_s  = 1'b0;
        im_addr_s = '0;
        if (state_r == ST_FETCH) begin
            im_ren_s  = 1'b1;
            im_addr_s = base_r + ADDR_W'({tile_r, col_r});
        end else begin
            im_ren_s  = 1'b0;
            im_addr_s = '0;
        end
    end

    // State, counters and latched job configuration.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r <= ST_IDLE;
            col_r   <= 2'd0;
            tile_r  <= 4'd0;
            ntile_r <= 4'd0;
            base_r  <= '0;
        end else begin
            state_r <= state_s;
            col_r   <= (state_r == ST_FETCH) ? col_r + 2'd1 : 2'd0;
            if (accept_s) begin
                tile_r  <= 4'd0;
                ntile_r <= NTILE;
                base_r  <= BASE_ADDR;
            end else if (next_tile_s) begin
                tile_r <= tile_r + 4'd1;
            end
        end
    end

    // Registered buffer-side outputs.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            iload_r      <= 1'b0;
            icol_r       <= 2'd0;
            shamt_r      <= 5'd0;
            odst_r       <= 4'd0;
            start_calc_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            iload_r      <= (state_r == ST_FETCH);
            start_calc_r <= (state_r == ST_DRAIN);
            done_r       <= empty_s | job_end_s;
            if (state_r == ST_FETCH) begin
                icol_r <= col_r;
            end
            if (accept_s) begin
                shamt_r <= CFG_SHAMT;
                odst_r  <= ODST_BASE;
            end else if (next_tile_s) begin
                odst_r <= odst_r + 4'd1;
            end
        end
    end

    assign IM_REN      = im_ren_s;
    assign IM_ADDR     = im_addr_s;
    assign IDATA1      = IM_RDATA;
    assign ILoad1      = iload_r;
    assign ICOL1       = icol_r;
    assign shamt1      = shamt_r;
    assign ODST1       = odst_r;
    assign START_CALC1 = start_calc_r;
    assign BUSY        = (state_r != ST_IDLE);
    assign DONE        = done_r;

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Scoreboard bench for im_fetch_ctrl: the driver predicts every read, column load,
// calc pulse and DONE with cycle stamps; a negedge monitor pops and compares.
module tb_im_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        START;
    logic [3:0]  NTILE;
    logic [5:0]  BASE_ADDR;
    logic [4:0]  CFG_SHAMT;
    logic [3:0]  ODST_BASE;
    logic        CALC_DONE;
    logic        IM_REN;
    logic [5:0]  IM_ADDR;
    logic [31:0] IM_RDATA = 32'h0;
    logic [31:0] IDATA1;
    logic        ILoad1;
    logic [1:0]  ICOL1;
    logic [4:0]  shamt1;
    logic [3:0]  ODST1;
    logic        START_CALC1;
    logic        BUSY;
    logic        DONE;

    im_fetch_ctrl dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .NTILE(NTILE), .BASE_ADDR(BASE_ADDR),
        .CFG_SHAMT(CFG_SHAMT), .ODST_BASE(ODST_BASE), .CALC_DONE(CALC_DONE),
        .IM_REN(IM_REN), .IM_ADDR(IM_ADDR), .IM_RDATA(IM_RDATA), .IDATA1(IDATA1),
        .ILoad1(ILoad1), .ICOL1(ICOL1), .shamt1(shamt1), .ODST1(ODST1),
        .START_CALC1(START_CALC1), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct { int cyc; logic [5:0] addr; logic [4:0] sh; } rd_t;
    typedef struct { int cyc; logic [1:0] col; logic [31:0] data; logic [3:0] odst; logic [4:0] sh; } ld_t;
    typedef struct { int cyc; logic [3:0] odst; } sc_t;
    typedef struct { int cyc; bit chk_sh; logic [4:0] sh; } dn_t;

    rd_t rd_q[$];
    ld_t ld_q[$];
    sc_t sc_q[$];
    dn_t dn_q[$];

    logic [31:0] mem [0:63];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic        exp_busy = 1'b0;
    logic [4:0]  model_sh = 5'd0;
    rd_t         m_rd;
    ld_t         m_ld;
    sc_t         m_sc;
    dn_t         m_dn;

    always @(posedge CLK) cyc <= cyc + 1;

    // Synchronous IM: data for an address appears one cycle after the read.
    always @(posedge CLK) IM_RDATA <= IM_REN ? mem[IM_ADDR] : 32'h0BAD_0BAD;

    task automatic check(input bit ok, input string name, input string msg);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, msg);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            START = 1'b0;
            CALC_DONE = 1'b0;
            exp_busy = 1'b0;
        end
    endtask

    task automatic apply_reset();
        RSTN = 1'b0;
        START = 1'b0;
        CALC_DONE = 1'b0;
        #1;
        check(ILoad1 === 1'b0 && ICOL1 === 2'd0 && shamt1 === 5'd0 && ODST1 === 4'd0 &&
              START_CALC1 === 1'b0 && DONE === 1'b0 && BUSY === 1'b0 && IM_REN === 1'b0 &&
              IM_ADDR === 6'd0, "reset_outputs",
              $sformatf("got ld=%b col=%0d sh=%0d odst=%0d sc=%b done=%b busy=%b ren=%b addr=%0h, want all 0",
                        ILoad1, ICOL1, shamt1, ODST1, START_CALC1, DONE, BUSY, IM_REN, IM_ADDR));
        rd_q.delete();
        ld_q.delete();
        sc_q.delete();
        dn_q.delete();
        model_sh = 5'd0;
        exp_busy = 1'b0;
        tick();
        tick();
        RSTN = 1'b1;
    endtask

    // dsel<0: random WAIT delay; cd_const: CALC_DONE held high; junk: stray START/CALC_DONE;
    // abort: reset during the second tile's fetch.
    task automatic run_job(input int nt, input logic [5:0] base, input logic [4:0] sh,
                           input logic [3:0] od, input int dsel, input bit cd_const,
                           input bit junk, input bit abort);
        int  f, t, d, a;
        rd_t r;
        ld_t l;
        sc_t s;
        dn_t dn;
        START = 1'b1;
        NTILE = 4'(nt);
        BASE_ADDR = base;
        CFG_SHAMT = sh;
        ODST_BASE = od;
        CALC_DONE = 1'b0;
        f = cyc + 1;
        if (nt == 0) begin
            dn.cyc = f; dn.chk_sh = 1'b0; dn.sh = model_sh;
            dn_q.push_back(dn);
            tick();
            START = 1'b0;
            exp_busy = 1'b0;
            return;
        end
        model_sh = sh;
        for (int k = 0; k < nt; k++) begin
            for (int c = 0; c < 4; c++) begin
                a = (int'(base) + 4 * k + c) % 64;
                r.cyc = f + c; r.addr = 6'(a); r.sh = sh;
                rd_q.push_back(r);
                l.cyc = f + 1 + c; l.col = 2'(c); l.data = mem[a];
                l.odst = 4'((int'(od) + k) % 16); l.sh = sh;
                ld_q.push_back(l);
            end
            s.cyc = f + 5; s.odst = 4'((int'(od) + k) % 16);
            sc_q.push_back(s);
            d = (dsel < 0) ? int'($urandom_range(0, 4)) : dsel;
            t = f + 5 + d;
            for (int x = f; x <= t; x++) begin
                tick();
                exp_busy = 1'b1;
                if (abort && k == 1 && x == f + 1) begin
                    apply_reset();
                    return;
                end
                if (x == t) CALC_DONE = 1'b1;
                else if (x <= f + 4) CALC_DONE = cd_const ? 1'b1 : (junk ? 1'($urandom_range(0, 1)) : 1'b0);
                else CALC_DONE = 1'b0;
                START = junk ? 1'($urandom_range(0, 1)) : 1'b0;
                if (START) begin
                    NTILE = 4'($urandom);
                    BASE_ADDR = 6'($urandom);
                    CFG_SHAMT = 5'($urandom);
                    ODST_BASE = 4'($urandom);
                end
            end
            f = t + 1;
        end
        dn.cyc = f; dn.chk_sh = 1'b1; dn.sh = sh;
        dn_q.push_back(dn);
        tick();
        START = 1'b0;
        CALC_DONE = 1'b0;
        exp_busy = 1'b0;
    endtask

    // Monitor: compare every DUT output event against the scoreboard.
    always @(negedge CLK) begin
        if (RSTN === 1'b1) begin
            check(BUSY === exp_busy, "busy", $sformatf("cyc %0d got %b want %b", cyc, BUSY, exp_busy));
            if (IM_REN === 1'b1) begin
                check(rd_q.size() != 0, "read_expected", $sformatf("cyc %0d got read addr %0h want none", cyc, IM_ADDR));
                if (rd_q.size() != 0) begin
                    m_rd = rd_q.pop_front();
                    check(cyc == m_rd.cyc && IM_ADDR === m_rd.addr && shamt1 === m_rd.sh, "read",
                          $sformatf("got cyc %0d addr %0h sh %0d want cyc %0d addr %0h sh %0d",
                                    cyc, IM_ADDR, shamt1, m_rd.cyc, m_rd.addr, m_rd.sh));
                end
            end else begin
                check(IM_ADDR === 6'd0, "addr_idle", $sformatf("cyc %0d got %0h want 0", cyc, IM_ADDR));
            end
            if (ILoad1 === 1'b1) begin
                check(ld_q.size() != 0, "load_expected", $sformatf("cyc %0d got ILoad1 want none", cyc));
                if (ld_q.size() != 0) begin
                    m_ld = ld_q.pop_front();
                    check(cyc == m_ld.cyc && ICOL1 === m_ld.col && IDATA1 === m_ld.data &&
                          ODST1 === m_ld.odst && shamt1 === m_ld.sh, "load",
                          $sformatf("got cyc %0d col %0d data %h odst %0d sh %0d want cyc %0d col %0d data %h odst %0d sh %0d",
                                    cyc, ICOL1, IDATA1, ODST1, shamt1,
                                    m_ld.cyc, m_ld.col, m_ld.data, m_ld.odst, m_ld.sh));
                end
            end
            if (START_CALC1 === 1'b1) begin
                check(sc_q.size() != 0, "calc_expected", $sformatf("cyc %0d got START_CALC1 want none", cyc));
                if (sc_q.size() != 0) begin
                    m_sc = sc_q.pop_front();
                    check(cyc == m_sc.cyc && ODST1 === m_sc.odst, "start_calc",
                          $sformatf("got cyc %0d odst %0d want cyc %0d odst %0d", cyc, ODST1, m_sc.cyc, m_sc.odst));
                end
            end
            if (DONE === 1'b1) begin
                check(dn_q.size() != 0, "done_expected", $sformatf("cyc %0d got DONE want none", cyc));
                if (dn_q.size() != 0) begin
                    m_dn = dn_q.pop_front();
                    check(cyc == m_dn.cyc && (!m_dn.chk_sh || shamt1 === m_dn.sh), "done",
                          $sformatf("got cyc %0d sh %0d want cyc %0d sh %0d", cyc, shamt1, m_dn.cyc, m_dn.sh));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RSTN = 1'b0;
        START = 1'b0;
        NTILE = 4'd0;
        BASE_ADDR = 6'd0;
        CFG_SHAMT = 5'd0;
        ODST_BASE = 4'd0;
        CALC_DONE = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[16 + i] = 32'hA0A0_0000 + 32'(i);
        tick();
        apply_reset();
        idle(2);
        // single tile: CALC_DONE in cycle 8 means a WAIT delay of 2
        run_job(1, 6'h10, 5'd7, 4'd3, 2, 1'b0, 1'b0, 1'b0);
        idle(3);
        // address and destination wrap, CALC_DONE held high
        run_job(3, 6'h3C, 5'd9, 4'd15, 0, 1'b1, 1'b0, 1'b0);
        idle(2);
        run_job(0, 6'h00, 5'd31, 4'd5, 0, 1'b0, 1'b0, 1'b0);
        idle(2);
        // stray START / CALC_DONE while busy
        run_job(2, 6'h20, 5'd4, 4'd8, -1, 1'b0, 1'b1, 1'b0);
        idle(2);
        // reset during tile 1, then a clean single-tile job
        run_job(2, 6'h08, 5'd21, 4'd6, -1, 1'b0, 1'b0, 1'b1);
        run_job(1, 6'h10, 5'd7, 4'd3, 2, 1'b0, 1'b0, 1'b0);
        // back-to-back: second START lands in the DONE cycle
        run_job(1, 6'h30, 5'd3, 4'd2, -1, 1'b0, 1'b0, 1'b0);
        run_job(2, 6'h31, 5'd12, 4'd9, -1, 1'b0, 1'b0, 1'b0);
        repeat (25) begin
            run_job(int'($urandom_range(0, 5)), 6'($urandom), 5'($urandom), 4'($urandom),
                    -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            idle(int'($urandom_range(0, 2)));
        end
        idle(4);
        check(rd_q.size() == 0, "reads_drained", $sformatf("got %0d pending want 0", rd_q.size()));
        check(ld_q.size() == 0, "loads_drained", $sformatf("got %0d pending want 0", ld_q.size()));
        check(sc_q.size() == 0, "calcs_drained", $sformatf("got %0d pending want 0", sc_q.size()));
        check(dn_q.size() == 0, "dones_drained", $sformatf("got %0d pending want 0", dn_q.size()));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
